down_count_checker: RTL and testbench
=====================================

// Module: down_count_checker
// PURPOSE
//  Downstream monitor for the 4-bit synchronous down counter: samples the counter
//  output q each rising clk edge; the counter updates on the falling edge, so q is
//  stable at the sample point.
//  Checks each sample against the previous sample minus 1, modulo 2^WIDTH.
//  Acquires lock, flags sequence errors, and reports terminal-count and wrap events.
//  Sits between the counter and the test/status logic.
// PARAMETERS
//  WIDTH      4  width of the monitored count
//  LOCK_CNT   2  consecutive correct steps needed to enter LOCKED (1..15)
//  ERR_CNT_W  8  width of the saturating error counter
// PORTS
//  clk        in   1          clock; all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  en         in   1          check enable; 0 parks the FSM in IDLE
//  clr_err    in   1          clears err_sticky and err_count
//  q_in       in   WIDTH      counter output under test
//  locked     out  1          1 while FSM is in LOCKED
//  tc_pulse   out  1          1-cycle pulse: accepted sample == 0
//  wrap_pulse out  1          1-cycle pulse: correct step 0 -> 2^WIDTH-1
//  err_pulse  out  1          1-cycle pulse: step mismatch while LOCKED
//  err_sticky out  1          set by err_pulse; held until clr_err or rst
//  err_count  out  ERR_CNT_W  number of err_pulse events, saturating at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, prev=0, good=0. Reset wins over every input.
//  - Registers: prev (last sample) and good (run length, 0..LOCK_CNT).
//  - step_ok = (q_in == prev - 1), computed in WIDTH bits, so 0 -> max is a correct step.
//  - FSM states: IDLE, PRIME, SYNC, LOCKED. Transitions at each posedge, rst=0:
//    - any state, en=0 -> IDLE. Outputs hold, except the pulses, which are 0.
//    - IDLE, en=1 -> PRIME. prev<=q_in. No check is made.
//    - PRIME -> SYNC. prev<=q_in. If step_ok, good<=1, else good<=0.
//    - SYNC: prev<=q_in. step_ok increments good, else good<=0 and no error is raised.
//      When good reaches LOCK_CNT -> LOCKED.
//    - LOCKED: prev<=q_in. step_ok stays LOCKED. A mismatch raises err_pulse and
//      goes to SYNC with good<=0.
//  - Pulses are registered; each appears the cycle after the sample that caused it.
//    - tc_pulse: only in SYNC or LOCKED, when step_ok and q_in==0.
//    - wrap_pulse: only in SYNC or LOCKED, when step_ok, prev==0 and q_in==all-ones.
//  - err_count increments on err_pulse and saturates.
//  - clr_err and err_pulse in the same cycle: the error wins. Result is err_sticky=1,
//    err_count=1.
//  - A counter reset mid-run (q jumps to 0) is a mismatch: error if LOCKED, resync if SYNC.
//  - Deasserting en mid-run keeps err_sticky and err_count. Reasserting en re-primes.
// TESTING
//  1 rst=1 for 2 cycles, then en=1 with q_in following 15,14,13,12
//    -> locked=0 at first; locked=1 after the 3rd sample; no errors.
//  2 Locked, q_in ..,2,1,0,15,14
//    -> tc_pulse the cycle after sample 0; wrap_pulse the cycle after sample 15;
//       err_count stays 0.
//  3 Locked, q_in 9,8,5,4,3
//    -> err_pulse once, err_count=1, err_sticky=1; locked drops, relocks after 4,3.
//  4 Locked, q_in jumps 6 -> 0 (counter rst)
//    -> err_pulse=1, FSM to SYNC; relock after 15,14.
//  5 Same cycle as an err_pulse: assert clr_err
//    -> err_sticky=1, err_count=1. Next cycle clr_err alone -> both 0.
//  6 Force 300 mismatches with ERR_CNT_W=8 -> err_count stays 255.
//    Then en=0 -> locked=0, err_count still 255.

Source files
------------

// File: rtl/down_count_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : down_count_checker
// Description : Monitors a free-running down counter. Each sample of q_in is
//               checked against the previous sample minus one (mod 2^WIDTH).
//               The checker locks after LOCK_CNT good steps, flags mismatches
//               seen while locked, and reports terminal-count and wrap events.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module down_count_checker #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_err,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 locked,
  output logic                 tc_pulse,
  output logic                 wrap_pulse,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Run-length counter only needs to reach LOCK_CNT, which is at most 15.
  localparam int                 GOOD_W   = 4;
  localparam logic [GOOD_W-1:0]  LOCK_TGT = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0]  GOOD_ONE = GOOD_W'(1);
  localparam logic [WIDTH-1:0]   Q_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0]   Q_ZERO   = '0;
  localparam logic [WIDTH-1:0]   Q_MAX    = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  prev;
  logic [GOOD_W-1:0] good;

  logic              step_ok;
  logic              is_tc;
  logic              is_wrap;
  logic [GOOD_W-1:0] good_inc;

  // Step check is done in WIDTH bits so 0 -> all-ones counts as a correct step.
  assign step_ok  = (q_in == (prev - Q_ONE));
  assign is_tc    = step_ok && (q_in == Q_ZERO);
  assign is_wrap  = step_ok && (prev == Q_ZERO) && (q_in == Q_MAX);
  assign good_inc = good + GOOD_ONE;

  // Checker FSM with registered status, pulse and error-tracking outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      good       <= '0;
      locked     <= 1'b0;
      tc_pulse   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      tc_pulse   <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      // A clear is overridden below if an error is detected on the same edge.
      if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end

      if (!en) begin
        state  <= IDLE;
        good   <= '0;
        locked <= 1'b0;
      end else begin
        prev <= q_in;
        case (state)
          IDLE: begin
            state <= PRIME;
          end
          PRIME: begin
            good  <= step_ok ? GOOD_ONE : '0;
            state <= SYNC;
          end
          SYNC: begin
            tc_pulse   <= is_tc;
            wrap_pulse <= is_wrap;
            if (step_ok) begin
              if (good_inc >= LOCK_TGT) begin
                good   <= LOCK_TGT;
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                good <= good_inc;
              end
            end else begin
              // Mismatches while synchronising only restart the run.
              good <= '0;
            end
          end
          LOCKED: begin
            tc_pulse   <= is_tc;
            wrap_pulse <= is_wrap;
            if (!step_ok) begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (clr_err) begin
                err_count <= CNT_ONE;
              end else if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_ONE;
              end
              good   <= '0;
              state  <= SYNC;
              locked <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_down_count_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_down_count_checker
// Description : Scoreboard bench for down_count_checker. Stimulus pushes the
//               expected outputs from a sample-history reference model; a
//               monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_down_count_checker;

  localparam int WIDTH     = 4;
  localparam int LOCK_CNT  = 2;
  localparam int ERR_CNT_W = 8;
  localparam int MODV      = 1 << WIDTH;
  localparam int CNT_SAT   = (1 << ERR_CNT_W) - 1;

  typedef struct packed {
    logic                 locked;
    logic                 tc;
    logic                 wrap;
    logic                 err;
    logic                 sticky;
    logic [ERR_CNT_W-1:0] cnt;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 clr_err;
  logic [WIDTH-1:0]     q_in;
  logic                 locked;
  logic                 tc_pulse;
  logic                 wrap_pulse;
  logic                 err_pulse;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  down_count_checker #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_err   (clr_err),
    .q_in      (q_in),
    .locked    (locked),
    .tc_pulse  (tc_pulse),
    .wrap_pulse(wrap_pulse),
    .err_pulse (err_pulse),
    .err_sticky(err_sticky),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the sample history since enable, in plain integers.
  int m_prev   = 0;   // last accepted sample
  int m_seen   = 0;   // samples since enable, capped at 2
  int m_run    = 0;   // consecutive correct steps
  bit m_locked = 0;
  bit m_sticky = 0;
  int m_cnt    = 0;

  task automatic model(input bit r, input bit e, input bit c, input int q);
    exp_t x;
    bit ok, tc, wrap, err;
    tc = 0; wrap = 0; err = 0;
    if (r) begin
      m_prev = 0; m_seen = 0; m_run = 0; m_locked = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      if (c) begin
        m_sticky = 0;
        m_cnt    = 0;
      end
      if (!e) begin
        m_seen = 0; m_run = 0; m_locked = 0;
      end else begin
        ok = (q == (m_prev + MODV - 1) % MODV);
        if (m_seen >= 2) begin
          tc   = ok && (q == 0);
          wrap = ok && (m_prev == 0) && (q == MODV - 1);
        end
        if (m_seen >= 1) begin
          if (m_locked) begin
            if (!ok) begin
              err = 1; m_locked = 0; m_run = 0;
            end
          end else begin
            m_run = ok ? m_run + 1 : 0;
            if (m_seen >= 2 && m_run >= LOCK_CNT) m_locked = 1;
          end
        end
        if (err) begin
          m_sticky = 1;
          m_cnt    = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
        end
        m_prev = q;
        if (m_seen < 2) m_seen++;
      end
    end
    x.locked = m_locked;
    x.tc     = tc;
    x.wrap   = wrap;
    x.err    = err;
    x.sticky = m_sticky;
    x.cnt    = ERR_CNT_W'(m_cnt);
    exp_q.push_back(x);
  endtask

  // Drive one cycle of stimulus and record what the DUT must show afterwards.
  task automatic step(input bit r, input bit e, input bit c, input int q);
    @(negedge clk);
    rst     = r;
    en      = e;
    clr_err = c;
    q_in    = WIDTH'(q);
    model(r, e, c, q);
  endtask

  task automatic go(input int q);
    step(0, 1, 0, q);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({locked, tc_pulse, wrap_pulse, err_pulse, err_sticky, err_count} != e) begin
          errors++;
          $display("FAIL outputs t=%0t: got locked=%0d tc=%0d wrap=%0d err=%0d sticky=%0d cnt=%0d, expected locked=%0d tc=%0d wrap=%0d err=%0d sticky=%0d cnt=%0d",
                   $time, locked, tc_pulse, wrap_pulse, err_pulse, err_sticky, err_count,
                   e.locked, e.tc, e.wrap, e.err, e.sticky, e.cnt);
        end
      end
    end
  end

  initial begin
    int cur;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; q_in = '0;

    // Reset for two cycles, then lock onto 15,14,13,12 and run through the wrap.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int v = 15; v >= 0; v--) go(v);
    go(15); go(14);

    // Skipped values while locked, then relock on the following good steps.
    for (int v = 13; v >= 8; v--) go(v);
    go(5); go(4); go(3); go(2); go(1);

    // Counter reset mid-run: 6 -> 0 is a mismatch, relock after 15,14.
    for (int v = 0; v >= 0; v--) go(v);
    for (int v = 15; v >= 6; v--) go(v);
    go(0); go(15); go(14); go(13);

    // Clear in the same cycle as an error, then a lone clear.
    step(0, 1, 1, 5);
    step(0, 1, 1, 4);
    go(3);
    cur = 3;

    // Drive well past the saturation point of the error counter.
    for (int i = 0; i < 300; i++) begin
      cur = (cur + MODV - 1) % MODV; go(cur);
      cur = (cur + MODV - 1) % MODV; go(cur);
      cur = (cur + 7) % MODV;        go(cur);
    end
    step(0, 0, 0, cur);
    step(0, 0, 0, cur);
    step(0, 0, 0, cur);

    // Re-enable and run randomized traffic around the directed cases.
    for (int i = 0; i < 1500; i++) begin
      bit r, e, c;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 99) < 95);
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 85) cur = (cur + MODV - 1) % MODV;
      else                             cur = int'($urandom_range(0, MODV - 1));
      step(r, e, c, cur);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
